fwd_hazard_unit: RTL and testbench



---
 rtl/rv_pipe_pkg.sv | 25 ++
 rtl/fwd_sel_calc.sv | 37 +++
 rtl/fwd_hazard_unit.sv | 100 ++++++++++
 tb/tb_fwd_hazard_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: operand-mux select codes and the per-stage
// destination-register record carried through EX, MEM and WB.
package rv_pipe_pkg;

    localparam int RV_REG_AW = 5;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;
    localparam logic [1:0] FWD_LINK = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [RV_REG_AW-1:0] rd;
        logic                 reg_write;
        logic                 is_load;
        logic                 is_link;
    } stage_rec_t;

    // A record "writes r" only for a live, non-x0 destination.
    function automatic logic rec_writes(input stage_rec_t rec, input logic [RV_REG_AW-1:0] r);
        return rec.valid && rec.reg_write && (rec.rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/fwd_sel_calc.sv
// Operand-select calculation for one source operand, from the instruction
// currently in EX (lands in MEM next cycle) and the one in MEM (lands in WB).
module fwd_sel_calc
    import rv_pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              rs_used,
    input  stage_rec_t        ex_rec,
    input  stage_rec_t        mem_rec,
    output logic [1:0]        sel
);

    logic ex_hit;
    logic mem_hit;
    logic unused_mem_bits;

    assign ex_hit          = rs_used && rec_writes(ex_rec, rs);
    assign mem_hit         = rs_used && rec_writes(mem_rec, rs);
    assign unused_mem_bits = mem_rec.is_load ^ mem_rec.is_link;

    // The younger producer (EX) always wins; a load in EX cannot supply data
    // yet, so it falls through to MEM and the stall logic covers the gap.
    always_comb begin
        // NOTE: default first so every path assigns sel and no latch is inferred.
        sel = FWD_RF;
        if (ex_hit && ex_rec.is_link) begin
            sel = FWD_LINK;
        end else if (ex_hit && !ex_rec.is_load) begin
            sel = FWD_MEM;
        end else if (mem_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard control for the EX operand muxes of the
// 5-stage RV32I pipeline; selects are registered alongside ID/EX.
module fwd_hazard_unit
    import rv_pipe_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              id_is_link,
    input  logic              flush_ex,
    input  logic              freeze,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              load_use_stall,
    output logic              rf_bypass_a,
    output logic              rf_bypass_b
);

    localparam logic [REG_AW:0] NUM_REGS_W = (REG_AW + 1)'(NUM_REGS);

    stage_rec_t ex_rec;
    stage_rec_t mem_rec;
    stage_rec_t wb_rec;
    stage_rec_t id_rec;

    logic       rs1_live;
    logic       rs2_live;
    logic [1:0] next_a_sel;
    logic [1:0] next_b_sel;
    logic       unused_wb_bits;

    // An operand only matters for a real instruction reading an existing register.
    assign rs1_live = id_valid && id_rs1_used && ({1'b0, id_rs1} < NUM_REGS_W);
    assign rs2_live = id_valid && id_rs2_used && ({1'b0, id_rs2} < NUM_REGS_W);

    assign id_rec = '{valid:     id_valid,
                      rd:        id_rd,
                      reg_write: id_reg_write,
                      is_load:   id_is_load,
                      is_link:   id_is_link};

    fwd_sel_calc #(.REG_AW(REG_AW)) u_sel_a (
        .rs      (id_rs1),
        .rs_used (rs1_live),
        .ex_rec  (ex_rec),
        .mem_rec (mem_rec),
        .sel     (next_a_sel)
    );

    fwd_sel_calc #(.REG_AW(REG_AW)) u_sel_b (
        .rs      (id_rs2),
        .rs_used (rs2_live),
        .ex_rec  (ex_rec),
        .mem_rec (mem_rec),
        .sel     (next_b_sel)
    );

    // A redirect kills the consumer in ID anyway, so flush suppresses the stall.
    assign load_use_stall = ex_rec.is_load && !flush_ex &&
                            ((rs1_live && rec_writes(ex_rec, id_rs1)) ||
                             (rs2_live && rec_writes(ex_rec, id_rs2)));

    assign rf_bypass_a    = rs1_live && rec_writes(wb_rec, id_rs1);
    assign rf_bypass_b    = rs2_live && rec_writes(wb_rec, id_rs2);
    assign unused_wb_bits = wb_rec.is_load ^ wb_rec.is_link;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rec    <= '0;
            mem_rec   <= '0;
            wb_rec    <= '0;
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else if (!freeze) begin
            // NOTE: non-blocking assignments let the records shift in one edge without ordering hazards.
            wb_rec  <= mem_rec;
            mem_rec <= ex_rec;
            if (flush_ex || load_use_stall) begin
                ex_rec    <= '0;
                fwd_a_sel <= FWD_RF;
                fwd_b_sel <= FWD_RF;
            end else begin
                ex_rec    <= id_rec;
                fwd_a_sel <= next_a_sel;
                fwd_b_sel <= next_b_sel;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed hazard scenarios followed by
// randomized traffic, all compared against an in-flight instruction model.
module tb_fwd_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_is_load;
    logic       id_is_link;
    logic       flush_ex;
    logic       freeze;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       load_use_stall;
    logic       rf_bypass_a;
    logic       rf_bypass_b;

    fwd_hazard_unit #(.REG_AW(5), .NUM_REGS(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .id_rd          (id_rd),
        .id_reg_write   (id_reg_write),
        .id_is_load     (id_is_load),
        .id_is_link     (id_is_link),
        .flush_ex       (flush_ex),
        .freeze         (freeze),
        .fwd_a_sel      (fwd_a_sel),
        .fwd_b_sel      (fwd_b_sel),
        .load_use_stall (load_use_stall),
        .rf_bypass_a    (rf_bypass_a),
        .rf_bypass_b    (rf_bypass_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        n_tests++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Model: in-flight instructions indexed by age past ID (1=EX, 2=MEM, 3=WB).
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit ld;
        bit lk;
    } m_inst_t;

    m_inst_t m_pipe [1:3];
    int      m_sel_a;
    int      m_sel_b;
    bit      last_stall;
    bit      last_byp_a;
    bit      last_byp_b;

    function automatic bit m_writes(input int age, input int r);
        return m_pipe[age].v && m_pipe[age].rw && (m_pipe[age].rd == r) && (r != 0);
    endfunction

    // Youngest producer wins; a load one ahead has no data yet, so look one older.
    function automatic int m_sel(input bit v, input int r, input bit used);
        if (!v || !used || r == 0) return 0;
        if (m_writes(1, r)) begin
            if (m_pipe[1].lk) return 3;
            if (!m_pipe[1].ld) return 1;
        end
        if (m_writes(2, r)) return 2;
        return 0;
    endfunction

    function automatic bit m_load_hit(input bit v, input int r, input bit used);
        return v && used && m_writes(1, r) && m_pipe[1].ld;
    endfunction

    task automatic m_reset();
        for (int a = 1; a <= 3; a++) m_pipe[a] = '{v: 0, rd: 0, rw: 0, ld: 0, lk: 0};
        m_sel_a = 0;
        m_sel_b = 0;
    endtask

    // One pipeline cycle: drive ID, check every output against the model, clock.
    task automatic step(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                        input int rd, input bit rw, input bit ld, input bit lk,
                        input bit fl, input bit fz);
        bit      e_stall;
        bit      e_byp_a;
        bit      e_byp_b;
        int      n_a;
        int      n_b;
        m_inst_t n_pipe [1:3];
        logic [4:0] r1_b;
        logic [4:0] r2_b;
        logic [4:0] rd_b;
        r1_b = r1[4:0];
        r2_b = r2[4:0];
        rd_b = rd[4:0];
        id_valid     = v;
        id_rs1       = r1_b;
        id_rs2       = r2_b;
        id_rs1_used  = u1;
        id_rs2_used  = u2;
        id_rd        = rd_b;
        id_reg_write = rw;
        id_is_load   = ld;
        id_is_link   = lk;
        flush_ex     = fl;
        freeze       = fz;
        #1;
        e_stall = !fl && (m_load_hit(v, r1, u1) || m_load_hit(v, r2, u2));
        e_byp_a = v && u1 && m_writes(3, r1);
        e_byp_b = v && u2 && m_writes(3, r2);
        check("fwd_a_sel", {2'b0, fwd_a_sel}, 4'(m_sel_a));
        check("fwd_b_sel", {2'b0, fwd_b_sel}, 4'(m_sel_b));
        check("load_use_stall", {3'b0, load_use_stall}, {3'b0, e_stall});
        check("rf_bypass_a", {3'b0, rf_bypass_a}, {3'b0, e_byp_a});
        check("rf_bypass_b", {3'b0, rf_bypass_b}, {3'b0, e_byp_b});
        last_stall = load_use_stall;
        last_byp_a = rf_bypass_a;
        last_byp_b = rf_bypass_b;

        n_pipe = m_pipe;
        n_a    = m_sel_a;
        n_b    = m_sel_b;
        if (!fz) begin
            n_pipe[3] = m_pipe[2];
            n_pipe[2] = m_pipe[1];
            if (fl || e_stall) begin
                n_pipe[1] = '{v: 0, rd: 0, rw: 0, ld: 0, lk: 0};
                n_a = 0;
                n_b = 0;
            end else begin
                n_pipe[1] = '{v: v, rd: rd, rw: rw, ld: ld, lk: lk};
                n_a = m_sel(v, r1, u1);
                n_b = m_sel(v, r2, u2);
            end
        end
        @(posedge clk);
        if (rst_n) begin
            m_pipe  = n_pipe;
            m_sel_a = n_a;
            m_sel_b = n_b;
        end else begin
            m_reset();
        end
        #1;
    endtask

    task automatic nop();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_step(input bit allow_ctl);
        int v;
        int fl;
        int fz;
        v  = ($urandom_range(0, 9) != 0) ? 1 : 0;
        fl = (allow_ctl && $urandom_range(0, 9) == 0) ? 1 : 0;
        fz = (allow_ctl && $urandom_range(0, 9) == 0) ? 1 : 0;
        step(v[0], $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
             $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, fl[0], fz[0]);
    endtask

    initial begin
        m_reset();
        rst_n = 1'b0;

        // Reset with random ID traffic: nothing may leak to the outputs.
        for (int i = 0; i < 3; i++) rand_step(1'b1);
        check("rst_a_sel", {2'b0, fwd_a_sel}, 4'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("bubble_b_sel", {2'b0, fwd_b_sel}, 4'd0);

        // ALU chain: add x5; sub x6,x5; or x7,..,x5.
        step(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0);
        step(1, 5, 1, 3, 1, 6, 1, 0, 0, 0, 0);
        check("alu_ex_fwd", {2'b0, fwd_a_sel}, 4'd1);
        step(1, 4, 1, 5, 1, 7, 1, 0, 0, 0, 0);
        check("alu_mem_fwd", {2'b0, fwd_b_sel}, 4'd2);

        // Load-use: lw x7; add x8,x1,x7 stalls once, then gets the WB path.
        step(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 0);
        step(1, 1, 1, 7, 1, 8, 1, 0, 0, 0, 0);
        check("lu_stall_hi", {3'b0, last_stall}, 4'd1);
        check("lu_bubble", {fwd_a_sel, fwd_b_sel}, 4'd0);
        step(1, 1, 1, 7, 1, 8, 1, 0, 0, 0, 0);
        check("lu_stall_once", {3'b0, last_stall}, 4'd0);
        check("lu_wb_fwd", {2'b0, fwd_b_sel}, 4'd2);

        // Link then x0.
        step(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
        step(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);
        check("link_fwd", {2'b0, fwd_a_sel}, 4'd3);
        step(1, 2, 1, 3, 1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 1, 4, 1, 0, 0, 0, 0);
        check("x0_no_fwd", {fwd_a_sel, fwd_b_sel}, 4'd0);

        // Flush beats a load-use match.
        step(1, 1, 1, 0, 0, 10, 1, 1, 0, 0, 0);
        step(1, 10, 1, 0, 0, 11, 1, 0, 0, 1, 0);
        check("flush_no_stall", {3'b0, last_stall}, 4'd0);
        check("flush_bubble", {2'b0, fwd_a_sel}, 4'd0);
        step(1, 10, 1, 0, 0, 12, 1, 0, 0, 0, 0);
        check("post_flush_wb", {2'b0, fwd_a_sel}, 4'd2);

        // Freeze for three cycles mid-chain.
        step(1, 1, 1, 2, 1, 11, 1, 0, 0, 0, 0);
        step(1, 11, 1, 2, 1, 12, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, $urandom_range(0, 31), 1, $urandom_range(0, 31), 1, 13, 1, 0, 0, 0, 1);
            check("freeze_hold", {2'b0, fwd_a_sel}, 4'd1);
        end
        step(1, 11, 1, 12, 1, 14, 1, 0, 0, 0, 0);
        check("thaw_a", {2'b0, fwd_a_sel}, 4'd2);
        check("thaw_b", {2'b0, fwd_b_sel}, 4'd1);

        // WB bypass: add x9 reaches WB three cycles later, for one cycle only.
        step(1, 1, 1, 2, 1, 9, 1, 0, 0, 0, 0);
        nop();
        nop();
        step(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("wb_bypass_hi", {3'b0, last_byp_a}, 4'd1);
        step(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("wb_bypass_once", {3'b0, last_byp_a}, 4'd0);

        // Random traffic with occasional asynchronous reset between edges.
        for (int i = 0; i < 600; i++) begin
            if (i % 200 == 150) begin
                rst_n = 1'b0;
                #1;
                check("async_rst", {fwd_a_sel, fwd_b_sel}, 4'd0);
                m_reset();
                #1;
                rst_n = 1'b1;
            end
            rand_step(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
